axi_wr_slave: RTL and testbench

AXI3 write-channel slave that terminates the AW/W/B channels of `axi_interface` and converts each write burst into a stream of single-beat memory write commands toward the DDR controller command path. The block sits directly downstream of the interconnect-facing AXI interface. It handles one outstanding burst at a time and generates the B response after the final beat.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_burst_addr.sv | 30 +++
 rtl/axi_wr_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_wr_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes and the write-slave FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address generator; shared by the write and read slaves.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [3:0]        len_i,
  input  burst_e            burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] win_mask;
  logic [ADDR_W-1:0] incr_addr;

  always_comb begin
    step      = ADDR_W'(1) << size_i;
    // Wrap window is (len+1) transfers of 2^size bytes, aligned to its own size.
    win_mask  = (ADDR_W'({1'b0, len_i} + 5'd1) << size_i) - ADDR_W'(1);
    incr_addr = addr_i + step;
    case (burst_i)
      BURST_INCR: next_addr_o = incr_addr;
      BURST_WRAP: next_addr_o = (addr_i & ~win_mask) | (incr_addr & win_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI3 write slave: accepts one burst at a time, emits one memory write per W beat,
// and returns the B response once the final beat has been taken.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [ID_W-1:0]     awid,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ID_W-1:0]     wid,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                mem_wvalid,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_wready
);

  wr_state_e         state_q, state_d;
  logic              awready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;
  logic [2:0]        size_q;
  burst_e            burst_q;
  logic              err_q;
  logic              suppress_q;

  logic [ADDR_W-1:0] addr_adv;
  logic [ADDR_W-1:0] aw_lsb_mask;
  logic              cfg_err;
  logic              aw_fire, beat_fire, b_fire, last_beat, beat_err;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (addr_adv)
  );

  assign aw_lsb_mask = (ADDR_W'(1) << awsize) - ADDR_W'(1);
  assign cfg_err = (burst_e'(awburst) == BURST_RSVD) || (awsize > 3'd2) ||
                   ((burst_e'(awburst) == BURST_WRAP) &&
                    (!wrap_len_ok(awlen) || ((awaddr & aw_lsb_mask) != '0)));

  assign aw_fire   = (state_q == ST_IDLE) && awready_q && awvalid;
  assign beat_fire = (state_q == ST_DATA) && wvalid && wready;
  assign b_fire    = (state_q == ST_RESP) && bvalid_q && bready;
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = (wid != id_q) || (wlast != last_beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_fire) state_d = ST_DATA;
      ST_DATA: if (beat_fire && last_beat) state_d = ST_RESP;
      ST_RESP: if (b_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake-visible flags follow the state being entered, so they change with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= (state_d == ST_IDLE);
      bvalid_q  <= (state_d == ST_RESP);
      if (beat_fire && last_beat) begin
        bid_q   <= id_q;
        bresp_q <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
      end else if (b_fire) begin
        bid_q   <= '0;
        bresp_q <= RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      err_q      <= 1'b0;
      suppress_q <= 1'b0;
    end else if (aw_fire) begin
      addr_q     <= awaddr;
      id_q       <= awid;
      len_q      <= awlen;
      cnt_q      <= '0;
      size_q     <= awsize;
      burst_q    <= burst_e'(awburst);
      err_q      <= cfg_err;
      suppress_q <= cfg_err;
    end else if (beat_fire) begin
      cnt_q  <= cnt_q + 4'd1;
      addr_q <= addr_adv;
      err_q  <= err_q || beat_err;
    end
  end

  always_comb begin
    awready    = awready_q;
    bvalid     = bvalid_q;
    bid        = bid_q;
    bresp      = bresp_q;
    wready     = 1'b0;
    mem_wvalid = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if (state_q == ST_DATA) begin
      if (suppress_q) begin
        wready = 1'b1;
      end else begin
        wready     = mem_wready;
        mem_wvalid = wvalid;
        mem_waddr  = addr_q;
        mem_wdata  = wdata;
        mem_wstrb  = wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: bursts of each type, backpressure, error responses and reset.
module tb_axi_wr_slave;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [3:0]  wid = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_wready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mem    = 0;
  int m0;

  axi_wr_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wready(mem_wready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (mem_wvalid && mem_wready) n_mem++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic aw(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                    input logic [2:0] sz, input logic [1:0] bu);
    chk("awready_before_aw", awready, 1'b1);
    awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("awready_after_aw", awready, 1'b0);
    $display("AW  addr=0x%08h id=%0d len=%0d size=%0d burst=%0d", a, id, len, sz, bu);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] id,
                      input logic last, input logic [31:0] exp_addr, input logic exp_v);
    wvalid = 1'b1; wdata = d; wstrb = s; wid = id; wlast = last;
    #1;
    chk("wready", wready, 1'b1);
    chk("mem_wvalid", mem_wvalid, exp_v);
    if (exp_v) begin
      chk("mem_waddr", mem_waddr, exp_addr);
      chk("mem_wdata", mem_wdata, d);
      chk("mem_wstrb", mem_wstrb, s);
    end
    $display("W   data=0x%08h strb=%b id=%0d last=%0b -> mem_wvalid=%0b mem_waddr=0x%08h",
             d, s, id, last, mem_wvalid, mem_waddr);
    tick;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic resp(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold);
    chk("bvalid", bvalid, 1'b1);
    chk("bid", bid, exp_id);
    chk("bresp", bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bid_hold", bid, exp_id);
      chk("bresp_hold", bresp, exp_resp);
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_after_b", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
    $display("B   id=%0d resp=%0d (held %0d cycles)", exp_id, exp_resp, hold);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 1'b0);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_mem_wvalid"}, mem_wvalid, 1'b0);
    chk({tag, "_bresp"}, bresp, 2'b00);
    chk({tag, "_bid"}, bid, 4'h0);
    chk({tag, "_mem_waddr"}, mem_waddr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 4'h0);
  endtask

  bit rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset: outputs low, W beats presented early are stalled.
    wvalid = 1'b1;
    #1;
    chk_all_zero("rst");
    tick;
    tick;
    aresetn = 1'b1;
    #1;
    chk("wready_idle", wready, 1'b0);
    wvalid = 1'b0;
    tick;
    chk("awready_post_rst", awready, 1'b1);
    $display("RST released, awready=%0b", awready);

    // INCR len=3 size=2 from 0x100
    m0 = n_mem;
    aw(32'h100, 4'd5, 4'd3, 3'd2, 2'b01);
    beat(32'h1111_0000, 4'hF, 4'd5, 1'b0, 32'h100, 1'b1);
    beat(32'h1111_0001, 4'hF, 4'd5, 1'b0, 32'h104, 1'b1);
    beat(32'h1111_0002, 4'hF, 4'd5, 1'b0, 32'h108, 1'b1);
    beat(32'h1111_0003, 4'hF, 4'd5, 1'b1, 32'h10C, 1'b1);
    resp(4'd5, 2'b00, 0);
    chk("incr_mem_count", n_mem - m0, 4);

    // WRAP len=3 size=2 from 0x108
    aw(32'h108, 4'd3, 4'd3, 3'd2, 2'b10);
    beat(32'h2222_0000, 4'hF, 4'd3, 1'b0, 32'h108, 1'b1);
    beat(32'h2222_0001, 4'hF, 4'd3, 1'b0, 32'h10C, 1'b1);
    beat(32'h2222_0002, 4'hF, 4'd3, 1'b0, 32'h100, 1'b1);
    beat(32'h2222_0003, 4'hF, 4'd3, 1'b1, 32'h104, 1'b1);
    resp(4'd3, 2'b00, 0);

    // FIXED len=1 at 0x40, partial strobes pass through
    aw(32'h40, 4'd1, 4'd1, 3'd2, 2'b00);
    beat(32'h3333_0000, 4'b0101, 4'd1, 1'b0, 32'h40, 1'b1);
    beat(32'h3333_0001, 4'b1010, 4'd1, 1'b1, 32'h40, 1'b1);
    resp(4'd1, 2'b00, 0);

    // INCR with mem_wready 1,0,0,1,1,1 and a slow bready
    m0 = n_mem;
    aw(32'h200, 4'd7, 4'd3, 3'd2, 2'b01);
    begin
      int b;
      b = 0;
      for (int c = 0; c < 6; c++) begin
        mem_wready = rdy_pat[c];
        wvalid = 1'b1; wdata = 32'h4444_0000 + b; wstrb = 4'hF; wid = 4'd7; wlast = (b == 3);
        #1;
        chk("tog_wready", wready, rdy_pat[c]);
        chk("tog_mem_wvalid", mem_wvalid, 1'b1);
        chk("tog_mem_waddr", mem_waddr, 32'h200 + 4 * b);
        chk("tog_mem_wdata", mem_wdata, 32'h4444_0000 + b);
        $display("W   cycle=%0d mem_wready=%0b wready=%0b mem_waddr=0x%08h", c, rdy_pat[c], wready, mem_waddr);
        tick;
        if (rdy_pat[c]) b++;
      end
      wvalid = 1'b0; wlast = 1'b0; mem_wready = 1'b1;
    end
    chk("tog_mem_count", n_mem - m0, 4);
    resp(4'd7, 2'b00, 3);

    // Reserved burst: data sunk even with memory stalled, SLVERR
    m0 = n_mem;
    mem_wready = 1'b0;
    aw(32'h80, 4'd9, 4'd2, 3'd2, 2'b11);
    beat(32'h5555_0000, 4'hF, 4'd9, 1'b0, 32'h0, 1'b0);
    beat(32'h5555_0001, 4'hF, 4'd9, 1'b0, 32'h0, 1'b0);
    beat(32'h5555_0002, 4'hF, 4'd9, 1'b1, 32'h0, 1'b0);
    mem_wready = 1'b1;
    resp(4'd9, 2'b10, 0);
    chk("rsvd_mem_count", n_mem - m0, 0);

    // wid mismatch on beat 1: writes still happen, SLVERR
    m0 = n_mem;
    aw(32'h300, 4'd2, 4'd1, 3'd2, 2'b01);
    beat(32'h6666_0000, 4'hF, 4'd2, 1'b0, 32'h300, 1'b1);
    beat(32'h6666_0001, 4'hF, 4'd9, 1'b1, 32'h304, 1'b1);
    resp(4'd2, 2'b10, 0);
    chk("wid_mem_count", n_mem - m0, 2);

    // Reset after beat 1 of a len=3 burst
    m0 = n_mem;
    aw(32'h400, 4'd4, 4'd3, 3'd2, 2'b01);
    beat(32'h7777_0000, 4'hF, 4'd4, 1'b0, 32'h400, 1'b1);
    wvalid = 1'b1; wdata = 32'h7777_0001; wstrb = 4'hF; wid = 4'd4;
    aresetn = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick;
    chk_all_zero("midrst_hold");
    aresetn = 1'b1;
    wvalid = 1'b0;
    #1;
    chk("awready_at_release", awready, 1'b0);
    tick;
    chk("awready_after_release", awready, 1'b1);
    chk("bvalid_after_release", bvalid, 1'b0);
    chk("midrst_mem_count", n_mem - m0, 1);
    $display("RST mid-burst done, awready=%0b bvalid=%0b", awready, bvalid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
